// File: rtl/bus_pkg.sv
// Shared bus definitions: widths, slave window base bytes and the responder FSM encoding.
package bus_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_OFS_W  = 5;
  localparam int ADDR_W     = 16;

  // Upper address byte of each slave window, as decoded by the bus address decoder.
  localparam logic [4:0][7:0] SLV_BASE = {8'h04, 8'h03, 8'h02, 8'h01, 8'h00};

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_t;
endpackage

// File: rtl/bus_slave_mem_if.sv
// Slave-side bus signals for one select line; master drives requests, slave returns data/status.
interface bus_slave_mem_if #(parameter int DATA_W = bus_pkg::DEF_DATA_W);
  import bus_pkg::*;

  logic              s_sel;
  logic              s_wr;
  logic [ADDR_W-1:0] s_address;
  logic [DATA_W-1:0] s_din;
  logic [DATA_W-1:0] s_dout;
  logic              s_rvalid;
  logic              s_err;
  logic              s_busy;

  modport master (
    output s_sel, s_wr, s_address, s_din,
    input  s_dout, s_rvalid, s_err, s_busy
  );

  modport slave (
    input  s_sel, s_wr, s_address, s_din,
    output s_dout, s_rvalid, s_err, s_busy
  );
endinterface

// File: rtl/bus_mem_array.sv
// Word register array: one write port, one registered read port that returns 0 when not enabled.
module bus_mem_array
  import bus_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int OFS_W  = DEF_OFS_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [OFS_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [OFS_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**OFS_W];

  // Contents are cleared by the owner's INIT sweep, so the array itself has no reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Zero when idle so the slave's return data can be OR-combined with other slaves.
  always_ff @(posedge clk) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= mem[raddr];
    else         rdata <= '0;
  end
endmodule

// File: rtl/bus_slave_mem.sv
// Bus slave memory: post-reset clear sweep, in-window range check, 1-cycle reads, error pulses.
module bus_slave_mem
  import bus_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int OFS_W  = DEF_OFS_W
) (
  input  logic               clk,
  input  logic               reset,
  bus_slave_mem_if.slave     bus
);
  state_t            state;
  logic [OFS_W-1:0]  ptr;
  logic              rvalid_q, err_q, busy_q;
  logic [DATA_W-1:0] rdata;
  logic [OFS_W-1:0]  offset;
  logic              in_range, acc_wr, acc_rd;
  logic              we, re;
  logic [OFS_W-1:0]  waddr;
  logic [DATA_W-1:0] wdata;
  logic              unused_addr;

  // Upper address byte is the decoder's business; only the low byte is checked here.
  assign offset      = bus.s_address[OFS_W-1:0];
  assign in_range    = (bus.s_address[7:OFS_W] == '0);
  assign unused_addr = ^bus.s_address[ADDR_W-1:8];

  assign acc_wr = (state == READY) && bus.s_sel && bus.s_wr  && in_range;
  assign acc_rd = (state == READY) && bus.s_sel && !bus.s_wr && in_range;

  assign we    = !reset && ((state == INIT) || acc_wr);
  assign re    = !reset && acc_rd;
  assign waddr = (state == INIT) ? ptr : offset;
  assign wdata = (state == INIT) ? '0  : bus.s_din;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= INIT;
      ptr      <= '0;
      busy_q   <= 1'b1;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          ptr      <= ptr + 1'b1;
          rvalid_q <= 1'b0;
          err_q    <= bus.s_sel;
          if (ptr == '1) begin
            state  <= READY;
            busy_q <= 1'b0;
          end
        end
        READY: begin
          rvalid_q <= acc_rd;
          err_q    <= bus.s_sel && !in_range;
        end
        default: state <= INIT;
      endcase
    end
  end

  bus_mem_array #(.DATA_W(DATA_W), .OFS_W(OFS_W)) u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .re    (re),
    .raddr (offset),
    .rdata (rdata)
  );

  assign bus.s_dout   = rdata;
  assign bus.s_rvalid = rvalid_q;
  assign bus.s_err    = err_q;
  assign bus.s_busy   = busy_q;
endmodule

// File: tb/tb_bus_slave_mem.sv
// Scoreboard bench for bus_slave_mem: stimulus pushes expected outputs, a negedge monitor compares.
module tb_bus_slave_mem;
  import bus_pkg::*;

  typedef struct packed {
    logic [31:0] dout;
    logic        rvalid;
    logic        err;
    logic        busy;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bus_slave_mem_if #(.DATA_W(32)) bus ();

  bus_slave_mem #(.DATA_W(32), .OFS_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t        exp_q[$];
  string       name_q[$];
  int          checks = 0;
  int          errors = 0;

  logic [31:0] mdl_mem [32];
  int          init_left = 0;

  exp_t  mon_e, mon_g;
  string mon_n;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_n = name_q.pop_front();
      mon_g = '{dout: bus.s_dout, rvalid: bus.s_rvalid, err: bus.s_err, busy: bus.s_busy};
      checks++;
      if (mon_g !== mon_e) begin
        errors++;
        $display("FAIL %s: got dout=%h rvalid=%b err=%b busy=%b, expected dout=%h rvalid=%b err=%b busy=%b",
                 mon_n, mon_g.dout, mon_g.rvalid, mon_g.err, mon_g.busy,
                 mon_e.dout, mon_e.rvalid, mon_e.err, mon_e.busy);
      end
    end
  end

  // Drive one bus cycle and queue what the outputs must look like after the edge.
  task automatic step(input logic r, input logic sel, input logic wr,
                      input logic [15:0] a, input logic [31:0] d, input string nm);
    exp_t e;
    logic inr;
    reset         = r;
    bus.s_sel     = sel;
    bus.s_wr      = wr;
    bus.s_address = a;
    bus.s_din     = d;
    e   = '0;
    inr = (a[7:5] == 3'b000);
    if (r) begin
      e.busy    = 1'b1;
      init_left = 32;
      for (int i = 0; i < 32; i++) mdl_mem[i] = '0;
    end else if (init_left > 0) begin
      e.err     = sel;
      init_left = init_left - 1;
      e.busy    = (init_left != 0);
    end else if (sel) begin
      if (!inr)    e.err = 1'b1;
      else if (wr) mdl_mem[a[4:0]] = d;
      else begin
        e.rvalid = 1'b1;
        e.dout   = mdl_mem[a[4:0]];
      end
    end
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input string nm);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 16'h0000, 32'h0, nm);
  endtask

  logic [15:0] a;

  initial begin
    reset = 1'b1;
    bus.s_sel = 1'b0; bus.s_wr = 1'b0; bus.s_address = '0; bus.s_din = '0;

    step(1'b1, 1'b0, 1'b0, 16'h0, 32'h0, "reset");
    step(1'b1, 1'b0, 1'b0, 16'h0, 32'h0, "reset");

    // INIT: busy for 32 cycles; a write on cycle 5 is rejected with err
    idle(4, "init_busy");
    step(1'b0, 1'b1, 1'b1, {SLV_BASE[1], 8'h03}, 32'h12345678, "init_access_err");
    idle(27, "init_busy");

    step(1'b0, 1'b1, 1'b0, {SLV_BASE[1], 8'h1F}, 32'h0, "read_1f_zero");
    step(1'b0, 1'b1, 1'b0, {SLV_BASE[1], 8'h03}, 32'h0, "init_write_dropped");
    idle(1, "idle_zero");

    step(1'b0, 1'b1, 1'b1, 16'h0105, 32'hDEADBEEF, "write_105");
    step(1'b0, 1'b1, 1'b0, 16'h0105, 32'h0,        "read_105_deadbeef");
    idle(1, "dout_zero_after_read");

    step(1'b0, 1'b1, 1'b0, 16'h0120, 32'h0,        "oor_read_err");
    step(1'b0, 1'b1, 1'b1, 16'h0125, 32'hAAAA5555, "oor_write_err");
    step(1'b0, 1'b1, 1'b0, 16'h0105, 32'h0,        "oor_mem_unchanged");
    step(1'b0, 1'b1, 1'b1, 16'h01E5, 32'h0BADF00D, "oor_high_err");
    step(1'b0, 1'b1, 1'b0, 16'h0105, 32'h0,        "oor_mem_unchanged2");

    // Upper byte is ignored by the slave
    step(1'b0, 1'b1, 1'b1, {SLV_BASE[4], 8'h07}, 32'hCAFE0007, "upper_byte_write");
    step(1'b0, 1'b1, 1'b0, {SLV_BASE[0], 8'h07}, 32'h0,        "upper_byte_read");

    for (int i = 0; i < 32; i++) begin
      a = {SLV_BASE[2], 3'b000, 5'(i)};
      step(1'b0, 1'b1, 1'b1, a, 32'hC0DE0000 ^ (32'h01010101 * i), "fill");
    end
    // Back-to-back reads, select toggling; unselected cycles carry wr=1 which must be ignored
    for (int i = 0; i < 32; i++) begin
      a = {SLV_BASE[2], 3'b000, 5'(i)};
      step(1'b0, (i % 2 == 0), (i % 2 != 0), a, 32'hFFFFFFFF, "toggle_read");
    end
    for (int i = 1; i < 32; i += 2) begin
      a = {SLV_BASE[3], 3'b000, 5'(i)};
      step(1'b0, 1'b1, 1'b0, a, 32'h0, "odd_unchanged");
    end

    // Reset during a read: no rvalid, full INIT again, memory cleared
    step(1'b0, 1'b1, 1'b1, 16'h0109, 32'h99887766, "pre_reset_write");
    step(1'b1, 1'b1, 1'b0, 16'h0109, 32'h0,        "reset_during_read");
    idle(32, "reinit_busy");
    step(1'b0, 1'b1, 1'b0, 16'h0109, 32'h0,        "cleared_after_reinit");
    step(1'b0, 1'b1, 1'b0, 16'h0105, 32'h0,        "cleared_after_reinit2");
    idle(1, "idle_zero");

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
